// File: rtl/uf_alu_if.sv
// Request/response and table-programming bundle for uf_alu_pipe.
// The master drives requests and table writes; the slave is the ALU.
interface uf_alu_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IDX_BITS = 1,
    parameter int unsigned CNT_W    = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [WIDTH-1:0]      in_a;
    logic [WIDTH-1:0]      in_b;
    logic                  uf_en;
    logic                  tbl_we;
    logic [2*IDX_BITS:0]   tbl_addr;
    logic [WIDTH-1:0]      tbl_wdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_res;
    logic [1:0]            out_src;
    logic [CNT_W-1:0]      uf_hits;

    modport master (
        output in_valid, in_op, in_a, in_b, uf_en, tbl_we, tbl_addr, tbl_wdata, out_ready,
        input  in_ready, out_valid, out_res, out_src, uf_hits
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, uf_en, tbl_we, tbl_addr, tbl_wdata, out_ready,
        output in_ready, out_valid, out_res, out_src, uf_hits
    );
endinterface

// File: rtl/uf_alu_pipe.sv
// Two-stage pipelined ALU with an optional uninterpreted-function table for ADD/SUB.
// Stage 1 holds the request; stage 2 computes the result into the output registers.
module uf_alu_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IDX_BITS = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic     clk,
    input logic     rstn,
    uf_alu_if.slave bus
);
    localparam int unsigned AddrW = 2 * IDX_BITS + 1;
    localparam int unsigned Depth = 1 << AddrW;

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpOr   = 3'd3;
    localparam logic [2:0] OpXor  = 3'd4;
    localparam logic [2:0] OpSlt  = 3'd5;
    localparam logic [2:0] OpSltu = 3'd6;

    localparam logic [1:0] SrcConc  = 2'd0;
    localparam logic [1:0] SrcIdent = 2'd1;
    localparam logic [1:0] SrcTable = 2'd2;

    logic [WIDTH-1:0] tbl_q [Depth];

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_uf_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_res_q;
    logic [1:0]       out_src_q;
    logic [CNT_W-1:0] hits_q;

    logic             adv;
    logic             accept;
    logic             is_add;
    logic             is_sub;
    logic [AddrW-1:0] rd_addr;
    logic [WIDTH-1:0] res_d;
    logic [1:0]       src_d;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv || !s1_valid_q;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_src   = out_src_q;
    assign bus.uf_hits   = hits_q;

    always_comb begin
        is_add  = (s1_op_q == OpAdd);
        is_sub  = (s1_op_q == OpSub);
        rd_addr = {is_sub, s1_a_q[IDX_BITS-1:0], s1_b_q[IDX_BITS-1:0]};
        src_d   = SrcConc;
        case (s1_op_q)
            OpAdd:   res_d = s1_a_q + s1_b_q;
            OpSub:   res_d = s1_a_q - s1_b_q;
            OpAnd:   res_d = s1_a_q & s1_b_q;
            OpOr:    res_d = s1_a_q | s1_b_q;
            OpXor:   res_d = s1_a_q ^ s1_b_q;
            OpSlt:   res_d = {{(WIDTH-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
            OpSltu:  res_d = {{(WIDTH-1){1'b0}}, s1_a_q < s1_b_q};
            default: res_d = s1_b_q;
        endcase
        // Zero-identity rules stay interpreted and take priority over the table.
        if (is_add && s1_a_q == '0) begin
            res_d = s1_b_q;
            src_d = SrcIdent;
        end else if (is_add && s1_b_q == '0) begin
            res_d = s1_a_q;
            src_d = SrcIdent;
        end else if (is_sub && s1_b_q == '0) begin
            res_d = s1_a_q;
            src_d = SrcIdent;
        end else if (is_sub && s1_a_q == s1_b_q) begin
            res_d = '0;
            src_d = SrcIdent;
        end else if (s1_uf_q && (is_add || is_sub)) begin
            res_d = tbl_q[rd_addr];
            src_d = SrcTable;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_src_q   <= SrcConc;
            hits_q      <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            if (bus.in_ready) begin
                s1_valid_q <= bus.in_valid;
            end
            if (accept) begin
                s1_op_q <= bus.in_op;
                s1_a_q  <= bus.in_a;
                s1_b_q  <= bus.in_b;
                s1_uf_q <= bus.uf_en;
            end
            if (adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_res_q <= res_d;
                    out_src_q <= src_d;
                end
            end
            if (out_valid_q && bus.out_ready && out_src_q == SrcTable && hits_q != '1) begin
                hits_q <= hits_q + 1'b1;
            end
            // Write lands at the edge, so a same-cycle read above still sees the old entry.
            if (bus.tbl_we) begin
                tbl_q[bus.tbl_addr] <= bus.tbl_wdata;
            end
        end
    end
endmodule

// File: tb/tb_uf_alu_pipe.sv
// Self-checking bench for uf_alu_pipe: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a behavioural model of the ALU and its table.
module tb_uf_alu_pipe;
    localparam int unsigned W   = 32;
    localparam int unsigned IB  = 1;
    localparam int unsigned CW  = 4;
    localparam int unsigned TD  = 1 << (2 * IB + 1);
    localparam int unsigned MAXH = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uf_alu_if #(.WIDTH(W), .IDX_BITS(IB), .CNT_W(CW)) bus ();

    uf_alu_pipe #(.WIDTH(W), .IDX_BITS(IB), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [W-1:0] tbl_m [TD];
    logic [W+1:0] exp_q [$];
    int           hits_m = 0;
    int           n_out = 0;
    logic         have_hold = 1'b0;
    logic [W-1:0] hold_res;
    logic [1:0]   hold_src;

    function automatic logic [W+1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic ue);
        longint unsigned idx;
        if (op == 0 && a == 0) return {2'd1, b};
        if (op == 0 && b == 0) return {2'd1, a};
        if (op == 1 && b == 0) return {2'd1, a};
        if (op == 1 && a == b) return {2'd1, {W{1'b0}}};
        if (ue && (op == 0 || op == 1)) begin
            idx = longint'(op) * (1 << (2 * IB)) + (a % (1 << IB)) * (1 << IB) + (b % (1 << IB));
            return {2'd2, tbl_m[idx]};
        end
        case (op)
            0: return {2'd0, a + b};
            1: return {2'd0, a - b};
            2: return {2'd0, a & b};
            3: return {2'd0, a | b};
            4: return {2'd0, a ^ b};
            5: return {2'd0, W'(($signed(a) < $signed(b)) ? 1 : 0)};
            6: return {2'd0, W'((a < b) ? 1 : 0)};
            default: return {2'd0, b};
        endcase
    endfunction

    // Scoreboard sampled mid-cycle: what is seen here happens at the next rising edge.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rstn) begin
            exp_q.delete();
            hits_m = 0;
            have_hold = 1'b0;
            for (int i = 0; i < TD; i++) tbl_m[i] = '0;
        end else begin
            check("uf_hits", 64'(bus.uf_hits), 64'(hits_m));
            if (have_hold) begin
                check("stall_res_hold", 64'(bus.out_res), 64'(hold_res));
                check("stall_src_hold", 64'(bus.out_src), 64'(hold_src));
            end
            have_hold = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("spurious_output", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_res", 64'(bus.out_res), 64'(e[W-1:0]));
                        check("sb_src", 64'(bus.out_src), 64'(e[W+1:W]));
                        if (e[W+1:W] == 2'd2 && hits_m < MAXH) hits_m++;
                    end
                end else begin
                    have_hold = 1'b1;
                    hold_res  = bus.out_res;
                    hold_src  = bus.out_src;
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_op(bus.in_op, bus.in_a, bus.in_b, bus.uf_en));
            if (bus.tbl_we) tbl_m[bus.tbl_addr] = bus.tbl_wdata;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ue);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.uf_en    = ue;
        #3;
        while (!bus.in_ready && n < 10) begin
            @(posedge clk);
            #4;
            n++;
        end
        check("accept_wait", 64'(n >= 10), 64'(0));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic write_tbl(input logic [2*IB:0] addr, input logic [W-1:0] data);
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = addr;
        bus.tbl_wdata = data;
        tick();
        bus.tbl_we = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ue;
        logic [W-1:0] res;
        logic [1:0]   src;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int n0;
        int n;
        logic saw_block;
        logic last_acc;

        vecs[0]  = '{3'd0, 32'd5,        32'd7,        1'b0, 32'd12,        2'd0};
        vecs[1]  = '{3'd1, 32'd3,        32'd5,        1'b0, 32'hFFFFFFFE,  2'd0};
        vecs[2]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,         2'd0};
        vecs[3]  = '{3'd6, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,         2'd0};
        vecs[4]  = '{3'd2, 32'hF0F0,     32'hFF00,     1'b0, 32'hF000,      2'd0};
        vecs[5]  = '{3'd3, 32'hF0F0,     32'hFF00,     1'b0, 32'hFFF0,      2'd0};
        vecs[6]  = '{3'd4, 32'hF0F0,     32'hFF00,     1'b0, 32'h0FF0,      2'd0};
        vecs[7]  = '{3'd7, 32'd1,        32'h1234,     1'b1, 32'h1234,      2'd0};
        vecs[8]  = '{3'd0, 32'd3,        32'd2,        1'b1, 32'hDEAD,      2'd2};
        vecs[9]  = '{3'd0, 32'd0,        32'd9,        1'b1, 32'd9,         2'd1};
        vecs[10] = '{3'd1, 32'd6,        32'd6,        1'b1, 32'd0,         2'd1};
        vecs[11] = '{3'd1, 32'd6,        32'd0,        1'b1, 32'd6,         2'd1};
        vecs[12] = '{3'd0, 32'd7,        32'd0,        1'b0, 32'd7,         2'd1};
        vecs[13] = '{3'd5, 32'd1,        32'hFFFFFFFF, 1'b1, 32'd0,         2'd0};
        vecs[14] = '{3'd0, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,         2'd0};
        vecs[15] = '{3'd0, 32'd5,        32'd5,        1'b1, 32'd0,         2'd2};

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.uf_en = 1'b0;
        bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_wdata = '0; bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_res",   64'(bus.out_res),   64'(0));
        check("rst_out_src",   64'(bus.out_src),   64'(0));
        check("rst_uf_hits",   64'(bus.uf_hits),   64'(0));
        check("rst_in_ready",  64'(bus.in_ready),  64'(1));

        // Directed vectors, one at a time, checking two-edge latency
        write_tbl(3'b010, 32'hDEAD);
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ue);
            check($sformatf("v%0d_not_early", i), 64'(bus.out_valid), 64'(0));
            tick();
            check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(1));
            check($sformatf("v%0d_res", i),   64'(bus.out_res),   64'(vecs[i].res));
            check($sformatf("v%0d_src", i),   64'(bus.out_src),   64'(vecs[i].src));
        end
        tick();
        check("hits_after_vectors", 64'(bus.uf_hits), 64'(2));

        // Back-to-back stream with a 3-cycle consumer stall
        n0 = n_out; sent = 0; saw_block = 1'b0;
        for (int c = 0; c < 30 && (n_out - n0) < 4; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            bus.in_valid  = (sent < 4);
            bus.in_op     = 3'd0;
            bus.in_a      = W'(sent + 1);
            bus.in_b      = W'(sent + 1);
            bus.uf_en     = 1'b0;
            #3;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        check("stall_sent",      64'(sent),         64'(4));
        check("stall_delivered", 64'(n_out - n0),   64'(4));
        check("stall_in_ready_drop", 64'(saw_block), 64'(1));
        tick(); tick();

        // Table write in the same cycle as the table read
        send(3'd1, 32'd1, 32'd3, 1'b1);
        bus.tbl_we = 1'b1; bus.tbl_addr = 3'b111; bus.tbl_wdata = 32'h55;
        tick();
        bus.tbl_we = 1'b0;
        check("wr_same_valid", 64'(bus.out_valid), 64'(1));
        check("wr_same_old",   64'(bus.out_res),   64'(0));
        check("wr_same_src",   64'(bus.out_src),   64'(2));
        send(3'd1, 32'd1, 32'd3, 1'b1);
        tick();
        check("wr_next_new",   64'(bus.out_res),   64'(32'h55));
        check("wr_next_src",   64'(bus.out_src),   64'(2));
        tick();

        // Randomized traffic against the model (table fixed during traffic)
        for (int i = 0; i < TD; i++) write_tbl((2 * IB + 1)'(i), W'($urandom));
        last_acc = 1'b1;
        for (int c = 0; c < 500; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (!bus.in_valid || last_acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_op    = 3'($urandom_range(0, 7));
                bus.in_a     = rnd_opnd();
                bus.in_b     = ($urandom_range(0, 5) == 0) ? bus.in_a : rnd_opnd();
                bus.uf_en    = $urandom_range(0, 1) != 0;
            end
            #3;
            last_acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("hits_saturated", 64'(hits_m == MAXH), 64'(1));

        // Reset with two ops in flight
        bus.out_ready = 1'b0;
        send(3'd0, 32'd5, 32'd7, 1'b0);
        send(3'd4, 32'd1, 32'd2, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst2_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst2_uf_hits",   64'(bus.uf_hits),   64'(0));
        check("rst2_in_ready",  64'(bus.in_ready),  64'(1));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst2_no_stale", 64'(bus.out_valid), 64'(0));
        end
        send(3'd0, 32'd3, 32'd2, 1'b1);
        tick();
        check("rst2_tbl_res", 64'(bus.out_res), 64'(0));
        check("rst2_tbl_src", 64'(bus.out_src), 64'(2));
        tick();
        check("rst2_hits_one", 64'(bus.uf_hits), 64'(1));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
